// File: rtl/pong_pkg.sv
// Shared screen geometry, coordinate widths, FSM state codes and score helper for the pong controller.
package pong_pkg;

  localparam int SCR_W     = 640;
  localparam int SCR_H     = 480;
  localparam int CTR_X     = 316;
  localparam int CTR_Y     = 236;
  localparam int PAD_RST_Y = 208;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_SCORE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // Saturating increment so a score can never pass the winning value.
  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle of the pong controller's video-timing, button and game-state signals.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic [11:0] hcount;
  logic [10:0] vcount;
  logic        start;
  logic        btn_l_up;
  logic        btn_l_dn;
  logic        btn_r_up;
  logic        btn_r_dn;
  x_t          ball_x;
  y_t          ball_y;
  y_t          pad_l_y;
  y_t          pad_r_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [2:0]  state;
  logic        game_over;

  modport master (
    output hcount, vcount, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, game_over
  );

  modport slave (
    input  hcount, vcount, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, game_over
  );

endinterface

// File: rtl/pong_paddle.sv
// One paddle: button-driven or ball-tracking vertical motion, saturating at the screen edges.
// Moves only on frame_tick while en is high.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int PAD_H     = 64,
  parameter int PAD_SPEED = 4,
  parameter int BALL_SIZE = 8,
  parameter bit AI_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic en,
  input  logic up,
  input  logic dn,
  input  y_t   ball_y,
  output y_t   y
);

  localparam int Y_MAX = SCR_H - PAD_H;

  y_t          y_q, y_d;
  logic        mv_up, mv_dn;
  logic [10:0] pad_c, ball_c;

  always_comb begin
    pad_c  = {2'b0, y_q} + 11'(PAD_H / 2);
    ball_c = {2'b0, ball_y} + 11'(BALL_SIZE / 2);
    if (AI_EN) begin
      // Dead band of PAD_SPEED keeps the tracking paddle from dithering around the ball.
      mv_up = (pad_c >= ball_c + 11'(PAD_SPEED));
      mv_dn = (ball_c >= pad_c + 11'(PAD_SPEED));
    end else begin
      mv_up = up & ~dn;
      mv_dn = dn & ~up;
    end

    y_d = y_q;
    if (frame_tick && en) begin
      if (mv_up)
        y_d = (y_q < Y_W'(PAD_SPEED)) ? '0 : y_q - Y_W'(PAD_SPEED);
      else if (mv_dn)
        y_d = ({2'b0, y_q} + 11'(PAD_SPEED) > 11'(Y_MAX)) ? Y_W'(Y_MAX) : y_q + Y_W'(PAD_SPEED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= Y_W'(PAD_RST_Y);
    else     y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game FSM and ball physics; all state advances once per frame (hcount==0, vcount==480).
// Define PONG_AI_EN to make the right paddle track the ball instead of following btn_r_*.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_W        = 8,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount,
  input  logic [10:0] vcount,
  input  logic        start,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  output x_t          ball_x,
  output y_t          ball_y,
  output y_t          pad_l_y,
  output y_t          pad_r_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [2:0]  state,
  output logic        game_over
);

`ifdef PONG_AI_EN
  localparam bit R_AI = 1'b1;
`else
  localparam bit R_AI = 1'b0;
`endif

  localparam logic signed [11:0] L_FACE = 12'(PAD_L_X + PAD_W);
  localparam logic signed [11:0] R_FACE = 12'(PAD_R_X - BALL_SIZE);
  localparam logic signed [11:0] X_MAX  = 12'(SCR_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(SCR_H - BALL_SIZE);
  localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

  logic        frame_tick;
  logic [2:0]  state_q, state_d;
  x_t          bx_q, bx_d;
  y_t          by_q, by_d;
  logic        dx_q, dx_d;       // 1 = moving right
  logic        dy_q, dy_d;       // 1 = moving down
  logic [3:0]  sl_q, sl_d, sr_q, sr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        left_won_q, left_won_d;

  logic signed [11:0] nx, ny;
  logic [10:0]        by_ext;
  logic               ov_l, ov_r;

  assign frame_tick = (hcount == 12'd0) && (vcount == 11'd480);

  always_comb begin
    nx     = {2'b0, bx_q} + (dx_q ? 12'(BALL_SPEED) : -12'(BALL_SPEED));
    ny     = {3'b0, by_q} + (dy_q ? 12'(BALL_SPEED) : -12'(BALL_SPEED));
    by_ext = {2'b0, by_q};
    ov_l   = (by_ext + 11'(BALL_SIZE) > {2'b0, pad_l_y}) && (by_ext < {2'b0, pad_l_y} + 11'(PAD_H));
    ov_r   = (by_ext + 11'(BALL_SIZE) > {2'b0, pad_r_y}) && (by_ext < {2'b0, pad_r_y} + 11'(PAD_H));

    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    sl_d       = sl_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    left_won_d = left_won_q;

    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          bx_d = X_W'(CTR_X);
          by_d = Y_W'(CTR_Y);
          if (start) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end
        end
        ST_SERVE: begin
          if (cnt_q == 16'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_PLAY: begin
          bx_d = nx[X_W-1:0];
          by_d = ny[Y_W-1:0];
          // Wall and paddle checks are independent so a corner hit flips both directions.
          if (ny <= 12'sd0) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (ny >= Y_MAX) begin
            by_d = Y_MAX[Y_W-1:0];
            dy_d = 1'b0;
          end
          if (!dx_q && nx <= L_FACE && ov_l) begin
            bx_d = L_FACE[X_W-1:0];
            dx_d = 1'b1;
          end else if (dx_q && nx >= R_FACE && ov_r) begin
            bx_d = R_FACE[X_W-1:0];
            dx_d = 1'b0;
          end else if (nx <= 12'sd0) begin
            bx_d       = '0;
            sr_d       = sat_inc(sr_q, WIN);
            left_won_d = 1'b0;
            state_d    = ST_SCORE;
          end else if (nx >= X_MAX) begin
            bx_d       = X_MAX[X_W-1:0];
            sl_d       = sat_inc(sl_q, WIN);
            left_won_d = 1'b1;
            state_d    = ST_SCORE;
          end
        end
        ST_SCORE: begin
          if (sl_q == WIN || sr_q == WIN) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_SERVE;
            bx_d    = X_W'(CTR_X);
            by_d    = Y_W'(CTR_Y);
            cnt_d   = '0;
            dx_d    = left_won_q;   // serve toward whoever just conceded
            dy_d    = ~dy_q;
          end
        end
        ST_OVER: begin
          if (start) begin
            sl_d    = '0;
            sr_d    = '0;
            state_d = ST_SERVE;
            bx_d    = X_W'(CTR_X);
            by_d    = Y_W'(CTR_Y);
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bx_q       <= X_W'(CTR_X);
      by_q       <= Y_W'(CTR_Y);
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      sl_q       <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      left_won_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      sl_q       <= sl_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      left_won_q <= left_won_d;
    end
  end

  pong_paddle #(
    .PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED), .BALL_SIZE(BALL_SIZE), .AI_EN(1'b0)
  ) u_pad_l (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .en(state_q != ST_OVER),
    .up(btn_l_up), .dn(btn_l_dn), .ball_y(by_q), .y(pad_l_y)
  );

  pong_paddle #(
    .PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED), .BALL_SIZE(BALL_SIZE), .AI_EN(R_AI)
  ) u_pad_r (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .en(state_q != ST_OVER),
    .up(btn_r_up), .dn(btn_r_dn), .ball_y(by_q), .y(pad_r_y)
  );

  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: one frame tick every two clocks, outputs sampled on the falling edge.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl dut (
    .clk(clk), .rst(rst),
    .hcount(bus.hcount), .vcount(bus.vcount), .start(bus.start),
    .btn_l_up(bus.btn_l_up), .btn_l_dn(bus.btn_l_dn),
    .btn_r_up(bus.btn_r_up), .btn_r_dn(bus.btn_r_dn),
    .ball_x(bus.ball_x), .ball_y(bus.ball_y),
    .pad_l_y(bus.pad_l_y), .pad_r_y(bus.pad_r_y),
    .score_l(bus.score_l), .score_r(bus.score_r),
    .state(bus.state), .game_over(bus.game_over)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.hcount = 12'd0;
      bus.vcount = 11'd480;
      @(negedge clk);
      bus.hcount = 12'd1;
    end
  endtask

  task automatic wait_score(input int budget);
    int n = 0;
    while (bus.state !== ST_SCORE && n < budget) begin
      tick_n(1);
      n++;
    end
    chk("wait_score", 32'(bus.state), 32'(ST_SCORE));
  endtask

  initial begin
    rst = 1'b1;
    bus.hcount = 12'd1; bus.vcount = 11'd0; bus.start = 1'b0;
    bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0; bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    chk("rst_bx", 32'(bus.ball_x), 316);
    chk("rst_by", 32'(bus.ball_y), 236);
    chk("rst_pl", 32'(bus.pad_l_y), 208);
    chk("rst_pr", 32'(bus.pad_r_y), 208);
    chk("rst_sl", 32'(bus.score_l), 0);
    chk("rst_sr", 32'(bus.score_r), 0);
    chk("rst_go", 32'(bus.game_over), 0);

    // Paddles in IDLE: saturation at top, both buttons hold, saturation at bottom.
    bus.btn_l_up = 1'b1; tick_n(60); bus.btn_l_up = 1'b0;
    chk("pl_sat_top", 32'(bus.pad_l_y), 0);
    bus.btn_r_up = 1'b1; bus.btn_r_dn = 1'b1; tick_n(3);
    chk("pr_both_hold", 32'(bus.pad_r_y), 208);
    bus.btn_r_up = 1'b0; tick_n(60); bus.btn_r_dn = 1'b0;
    chk("pr_sat_bot", 32'(bus.pad_r_y), 416);
    chk("idle_state", 32'(bus.state), 32'(ST_IDLE));
    chk("idle_bx", 32'(bus.ball_x), 316);

    bus.start = 1'b1; tick_n(1); bus.start = 1'b0;
    chk("serve_enter", 32'(bus.state), 32'(ST_SERVE));
    tick_n(59);
    chk("serve_59", 32'(bus.state), 32'(ST_SERVE));
    tick_n(1);
    chk("play_enter", 32'(bus.state), 32'(ST_PLAY));
    chk("play_enter_bx", 32'(bus.ball_x), 316);

    // Play 1: right/down from centre, bottom wall, right paddle at 416, top wall, miss left.
    tick_n(1);
    chk("p1_k1_bx", 32'(bus.ball_x), 318);
    chk("p1_k1_by", 32'(bus.ball_y), 238);
    tick_n(117);
    chk("p1_wall_bot", 32'(bus.ball_y), 472);
    tick_n(1);
    chk("p1_k119_by", 32'(bus.ball_y), 470);
    chk("p1_k119_bx", 32'(bus.ball_x), 554);
    tick_n(27);
    chk("p1_rhit_bx", 32'(bus.ball_x), 608);
    chk("p1_rhit_by", 32'(bus.ball_y), 416);
    tick_n(1);
    chk("p1_after_rhit", 32'(bus.ball_x), 606);
    tick_n(206);
    chk("p1_y2", 32'(bus.ball_y), 2);
    chk("p1_y2_bx", 32'(bus.ball_x), 194);
    tick_n(1);
    chk("p1_wall_top", 32'(bus.ball_y), 0);
    tick_n(1);
    chk("p1_after_top", 32'(bus.ball_y), 2);
    tick_n(84);
    chk("p1_no_lhit", 32'(bus.ball_x), 22);
    tick_n(10);
    chk("p1_x2_state", 32'(bus.state), 32'(ST_PLAY));
    tick_n(1);
    chk("p1_score_state", 32'(bus.state), 32'(ST_SCORE));
    chk("p1_score_r", 32'(bus.score_r), 1);
    chk("p1_score_l", 32'(bus.score_l), 0);
    tick_n(1);
    chk("p1_reserve", 32'(bus.state), 32'(ST_SERVE));
    chk("p1_reserve_bx", 32'(bus.ball_x), 316);
    chk("p1_reserve_by", 32'(bus.ball_y), 236);

    // Serve 2: move left paddle to 40; ball then served left and up.
    bus.btn_l_dn = 1'b1; tick_n(10); bus.btn_l_dn = 1'b0;
    chk("pl_move_dn", 32'(bus.pad_l_y), 40);
    tick_n(49);
    chk("s2_59", 32'(bus.state), 32'(ST_SERVE));
    tick_n(1);
    chk("s2_play", 32'(bus.state), 32'(ST_PLAY));
    tick_n(1);
    chk("p2_k1_bx", 32'(bus.ball_x), 314);
    chk("p2_k1_by", 32'(bus.ball_y), 234);
    tick_n(145);
    chk("p2_lhit_bx", 32'(bus.ball_x), 24);
    chk("p2_lhit_by", 32'(bus.ball_y), 56);
    tick_n(1);
    chk("p2_after_lhit_bx", 32'(bus.ball_x), 26);
    chk("p2_after_lhit_by", 32'(bus.ball_y), 58);

    // Left keeps scoring with the right paddle parked at 208 until the match ends.
    wait_score(400);
    chk("p2_score_l", 32'(bus.score_l), 1);
    chk("p2_score_r", 32'(bus.score_r), 1);
    tick_n(1);
    chk("s3_state", 32'(bus.state), 32'(ST_SERVE));
    bus.btn_r_up = 1'b1; tick_n(52); bus.btn_r_up = 1'b0;
    chk("pr_back", 32'(bus.pad_r_y), 208);
    for (int i = 2; i <= 9; i++) begin
      wait_score(400);
      chk("loop_score_l", 32'(bus.score_l), 32'(i));
      chk("loop_score_r", 32'(bus.score_r), 1);
      if (i < 9) begin
        tick_n(1);
        chk("loop_serve", 32'(bus.state), 32'(ST_SERVE));
      end
    end
    tick_n(1);
    chk("over_state", 32'(bus.state), 32'(ST_OVER));
    chk("over_go", 32'(bus.game_over), 1);
    chk("over_bx", 32'(bus.ball_x), 632);
    bus.btn_l_up = 1'b1; tick_n(1); bus.btn_l_up = 1'b0;
    chk("over_frozen_bx", 32'(bus.ball_x), 632);
    chk("over_frozen_pl", 32'(bus.pad_l_y), 40);
    chk("over_hold_sl", 32'(bus.score_l), 9);
    bus.start = 1'b1; tick_n(1); bus.start = 1'b0;
    chk("restart_state", 32'(bus.state), 32'(ST_SERVE));
    chk("restart_sl", 32'(bus.score_l), 0);
    chk("restart_sr", 32'(bus.score_r), 0);
    chk("restart_go", 32'(bus.game_over), 0);

    // Reset in the middle of play, with no frame tick around it.
    tick_n(60);
    tick_n(5);
    chk("mid_state", 32'(bus.state), 32'(ST_PLAY));
    chk("mid_bx", 32'(bus.ball_x), 326);
    chk("mid_by", 32'(bus.ball_y), 226);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst2_state", 32'(bus.state), 32'(ST_IDLE));
    chk("rst2_bx", 32'(bus.ball_x), 316);
    chk("rst2_by", 32'(bus.ball_y), 236);
    chk("rst2_pl", 32'(bus.pad_l_y), 208);
    chk("rst2_pr", 32'(bus.pad_r_y), 208);
    chk("rst2_go", 32'(bus.game_over), 0);
    tick_n(1);
    chk("rst2_idle_hold", 32'(bus.state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
